// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU-16 fetch front end: fetch states, operand codes
// that pull an extra word from memory, and the opcode word field layout.
package dcpu_pkg;

   typedef enum logic [2:0] {
      S_RST,
      S_REQ_OP,
      S_CAP_OP,
      S_REQ_A,
      S_CAP_A,
      S_REQ_B,
      S_CAP_B,
      S_OUT
   } fetch_state_e;

   localparam logic [5:0] NEXTWORD_IND_LO = 6'h10;
   localparam logic [5:0] NEXTWORD_IND_HI = 6'h17;
   localparam logic [5:0] NEXTWORD_ADDR   = 6'h1e;
   localparam logic [5:0] NEXTWORD_LIT    = 6'h1f;

   localparam int unsigned OP_LSB = 0;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned A_LSB  = 4;
   localparam int unsigned A_W    = 6;
   localparam int unsigned B_LSB  = 10;
   localparam int unsigned B_W    = 6;

   function automatic logic needs_next_word(input logic [5:0] code);
      return ((code >= NEXTWORD_IND_LO) && (code <= NEXTWORD_IND_HI)) ||
             (code == NEXTWORD_ADDR) || (code == NEXTWORD_LIT);
   endfunction

endpackage

// File: rtl/dcpu_oplen.sv
// Instruction length decode from the opcode word. For non-basic instructions the
// single operand field's extra word is reported on need_a_o, since it lands in ext_a.
module dcpu_oplen
   import dcpu_pkg::*;
#(
   parameter int unsigned DWIDTH = 16
) (
   input  logic [DWIDTH-1:0] word_i,
   output logic              need_a_o,
   output logic              need_b_o,
   output logic [1:0]        len_o
);

   logic [OP_W-1:0] op;
   logic [A_W-1:0]  fa;
   logic [B_W-1:0]  fb;

   always_comb begin
      op = word_i[OP_LSB +: OP_W];
      fa = word_i[A_LSB +: A_W];
      fb = word_i[B_LSB +: B_W];
      if (op != '0) begin
         need_a_o = needs_next_word(fa);
         need_b_o = needs_next_word(fb);
      end else begin
         need_a_o = needs_next_word(fb);
         need_b_o = 1'b0;
      end
      len_o = 2'd1 + {1'b0, need_a_o} + {1'b0, need_b_o};
   end

endmodule

// File: rtl/dcpu_ifetch.sv
// Instruction fetch front end: assembles one variable-length instruction at a time
// from synchronous memory and offers it to decode over a valid/ready handshake.
module dcpu_ifetch
   import dcpu_pkg::*;
#(
   parameter int unsigned           AWIDTH   = 16,
   parameter int unsigned           DWIDTH   = 16,
   parameter logic [AWIDTH-2:0]     RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_re,
   output logic [AWIDTH-2:0] memaddr,
   input  logic [DWIDTH-1:0] rmemdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DWIDTH-1:0] inst_word,
   output logic [DWIDTH-1:0] inst_ext_a,
   output logic [DWIDTH-1:0] inst_ext_b,
   output logic [1:0]        inst_len,
   output logic [AWIDTH-2:0] inst_pc,
   input  logic              skip,
   input  logic              redirect,
   input  logic [AWIDTH-2:0] redirect_pc
);

   fetch_state_e      state_q, state_d;
   logic [AWIDTH-2:0] ptr_q, ptr_d;
   logic [AWIDTH-2:0] pc_q, pc_d;
   logic              skip_q, skip_d;
   logic [DWIDTH-1:0] ir_q, ir_d;
   logic [DWIDTH-1:0] ext_a_q, ext_a_d;
   logic [DWIDTH-1:0] ext_b_q, ext_b_d;
   logic [1:0]        len_q, len_d;

   logic [DWIDTH-1:0] op_src;
   logic              need_a, need_b, done;
   logic [1:0]        op_len;

   // While capturing the opcode the word is still on the memory bus, not in ir_q.
   always_comb op_src = (state_q == S_CAP_OP) ? rmemdata : ir_q;

   dcpu_oplen #(.DWIDTH(DWIDTH)) u_oplen (
      .word_i   (op_src),
      .need_a_o (need_a),
      .need_b_o (need_b),
      .len_o    (op_len)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RST;
         ptr_q   <= RESET_PC;
         pc_q    <= '0;
         skip_q  <= 1'b0;
         ir_q    <= '0;
         ext_a_q <= '0;
         ext_b_q <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pc_q    <= pc_d;
         skip_q  <= skip_d;
         ir_q    <= ir_d;
         ext_a_q <= ext_a_d;
         ext_b_q <= ext_b_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      pc_d    = pc_q;
      skip_d  = skip_q;
      ir_d    = ir_q;
      ext_a_d = ext_a_q;
      ext_b_d = ext_b_q;
      len_d   = len_q;
      done    = 1'b0;
      case (state_q)
         S_RST:    state_d = S_REQ_OP;
         S_REQ_OP: begin
            pc_d    = ptr_q;
            ptr_d   = ptr_q + 1'b1;
            ext_a_d = '0;
            ext_b_d = '0;
            state_d = S_CAP_OP;
         end
         S_CAP_OP: begin
            ir_d  = rmemdata;
            len_d = op_len;
            if (need_a || need_b) state_d = S_REQ_A;
            else                  done    = 1'b1;
         end
         S_REQ_A: begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_CAP_A;
         end
         // The first extra-word slot carries b's word when only b needs one.
         S_CAP_A: begin
            if (need_a) begin
               ext_a_d = rmemdata;
               if (need_b) state_d = S_REQ_B;
               else        done    = 1'b1;
            end else begin
               ext_b_d = rmemdata;
               done    = 1'b1;
            end
         end
         S_REQ_B: begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_CAP_B;
         end
         S_CAP_B: begin
            ext_b_d = rmemdata;
            done    = 1'b1;
         end
         S_OUT: begin
            if (inst_ready) begin
               state_d = S_REQ_OP;
               skip_d  = skip;
            end
         end
         default: state_d = S_RST;
      endcase
      if (done) begin
         if (skip_q) begin
            skip_d  = 1'b0;
            state_d = S_REQ_OP;
         end else begin
            state_d = S_OUT;
         end
      end
      // Redirect overrides everything, including a coincident accept's skip.
      if (redirect && (state_q != S_RST)) begin
         state_d = S_REQ_OP;
         ptr_d   = redirect_pc;
         skip_d  = 1'b0;
      end
   end

   always_comb begin
      mem_re     = (state_q == S_REQ_OP) || (state_q == S_REQ_A) || (state_q == S_REQ_B);
      memaddr    = mem_re ? ptr_q : '0;
      inst_valid = (state_q == S_OUT);
      inst_word  = ir_q;
      inst_ext_a = ext_a_q;
      inst_ext_b = ext_b_q;
      inst_len   = len_q;
      inst_pc    = pc_q;
   end

endmodule

// File: tb/tb_dcpu_ifetch.sv
// Bench for dcpu_ifetch: directed scenarios followed by a randomized instruction
// stream, all checked against a word-level memory model of instruction assembly.
module tb_dcpu_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_re;
   logic [14:0] memaddr;
   logic [15:0] rmemdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst_word, inst_ext_a, inst_ext_b;
   logic [1:0]  inst_len;
   logic [14:0] inst_pc;
   logic        skip;
   logic        redirect;
   logic [14:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:32767];
   logic [14:0] rd_q [$];

   typedef struct {
      logic [15:0] word;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [1:0]  len;
   } ref_t;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) begin
         rmemdata <= mem[memaddr];
         rd_q.push_back(memaddr);
      end
   end

   dcpu_ifetch #(.AWIDTH(16), .DWIDTH(16), .RESET_PC(15'h0100)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_re      (mem_re),
      .memaddr     (memaddr),
      .rmemdata    (rmemdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_word   (inst_word),
      .inst_ext_a  (inst_ext_a),
      .inst_ext_b  (inst_ext_b),
      .inst_len    (inst_len),
      .inst_pc     (inst_pc),
      .skip        (skip),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   function automatic bit nw(input int c);
      return (c >= 16 && c <= 23) || c == 30 || c == 31;
   endfunction

   // Words follow the opcode in order: a's word first, then b's (non-basic: b's word is "a").
   function automatic ref_t ref_at(input logic [14:0] pc);
      ref_t r;
      int idx = 1;
      int op, a, b;
      r.word = mem[pc];
      r.ea = '0;
      r.eb = '0;
      op = int'(r.word % 16'd16);
      a  = int'((r.word / 16'd16) % 16'd64);
      b  = int'(r.word / 16'd1024);
      if (op != 0) begin
         if (nw(a)) begin r.ea = mem[15'(pc + 15'(idx))]; idx++; end
         if (nw(b)) begin r.eb = mem[15'(pc + 15'(idx))]; idx++; end
      end else if (nw(b)) begin
         r.ea = mem[15'(pc + 15'(idx))]; idx++;
      end
      r.len = 2'(idx);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (inst_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("valid_seen", 32'(inst_valid), 32'd1);
   endtask

   task automatic check_inst(input logic [14:0] pc, input int lat_exp, input int lat);
      ref_t r;
      r = ref_at(pc);
      chk("inst_word", 32'(inst_word), 32'(r.word));
      chk("inst_ext_a", 32'(inst_ext_a), 32'(r.ea));
      chk("inst_ext_b", 32'(inst_ext_b), 32'(r.eb));
      chk("inst_len", 32'(inst_len), 32'(r.len));
      chk("inst_pc", 32'(inst_pc), 32'(pc));
      chk("latency", 32'(lat), 32'(lat_exp));
   endtask

   task automatic accept(input bit s, input bit rd, input logic [14:0] tgt);
      inst_ready  = 1'b1;
      skip        = s;
      redirect    = rd;
      redirect_pc = tgt;
      rd_q.delete();
      step();
      inst_ready = 1'b0;
      skip       = 1'b0;
      redirect   = 1'b0;
      chk("valid_drop", 32'(inst_valid), 32'd0);
   endtask

   task automatic chk_reads(input string tag, input logic [14:0] exp [$]);
      chk({tag, "_count"}, 32'(rd_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < rd_q.size(); i++)
         chk(tag, 32'(rd_q[i]), 32'(exp[i]));
   endtask

   initial begin
      int n, lat, k;
      ref_t r, rs;
      logic [14:0] exp_pc, nxt, tgt;
      bit s, rd;

      rst = 1'b1; inst_ready = 1'b0; skip = 1'b0; redirect = 1'b0; redirect_pc = '0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      mem[15'h0100] = 16'h0402;
      mem[15'h0101] = 16'h7C01; mem[15'h0102] = 16'h0030;
      mem[15'h0103] = 16'h7C10; mem[15'h0104] = 16'h1234;
      mem[15'h0105] = 16'h79E1; mem[15'h0106] = 16'h1000; mem[15'h0107] = 16'h2000;
      mem[15'h0108] = 16'h0402;
      mem[15'h0109] = 16'h79E1; mem[15'h010A] = 16'h1000; mem[15'h010B] = 16'h2000;
      mem[15'h010C] = 16'h0402;
      mem[15'h010D] = 16'h7C01;
      mem[15'h7FFF] = 16'h7C01; mem[15'h0000] = 16'h5555;

      repeat (3) step();
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_memaddr", 32'(memaddr), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_word", 32'(inst_word), 32'd0);
      chk("rst_ext_a", 32'(inst_ext_a), 32'd0);
      chk("rst_ext_b", 32'(inst_ext_b), 32'd0);
      chk("rst_len", 32'(inst_len), 32'd0);
      chk("rst_pc", 32'(inst_pc), 32'd0);

      rst = 1'b0;
      rd_q.delete();
      step();
      chk("first_re", 32'(mem_re), 32'd1);
      chk("first_addr", 32'(memaddr), 32'h0100);
      wait_valid(n);
      check_inst(15'h0100, 2, n);

      accept(1'b0, 1'b0, '0);
      chk("next_re", 32'(mem_re), 32'd1);
      chk("next_addr", 32'(memaddr), 32'h0101);
      wait_valid(n);
      check_inst(15'h0101, 4, n);
      chk("set_ext_b", 32'(inst_ext_b), 32'h0030);

      accept(1'b0, 1'b0, '0);
      wait_valid(n);
      check_inst(15'h0103, 4, n);
      chk("nb_ext_a", 32'(inst_ext_a), 32'h1234);

      accept(1'b0, 1'b0, '0);
      wait_valid(n);
      check_inst(15'h0105, 6, n);
      chk_reads("len3_reads", '{15'h0105, 15'h0106, 15'h0107});

      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", 32'(inst_valid), 32'd1);
         chk("hold_re", 32'(mem_re), 32'd0);
         chk("hold_word", 32'(inst_word), 32'h79E1);
         chk("hold_ext", {inst_ext_a, inst_ext_b}, 32'h1000_2000);
         chk("hold_pc_len", {15'd0, inst_pc, inst_len}, {15'd0, 15'h0105, 2'd3});
      end
      accept(1'b0, 1'b0, '0);
      chk("after_hold_addr", 32'(memaddr), 32'h0108);
      wait_valid(n);
      check_inst(15'h0108, 2, n);

      accept(1'b1, 1'b0, '0);
      wait_valid(n);
      check_inst(15'h010C, 8, n);
      chk_reads("skip_reads", '{15'h0109, 15'h010A, 15'h010B, 15'h010C});

      accept(1'b0, 1'b0, '0);
      repeat (2) step();
      chk("reqa_addr", 32'(memaddr), 32'h010E);
      step();
      redirect = 1'b1; redirect_pc = 15'h7FFF;
      rd_q.delete();
      step();
      redirect = 1'b0;
      chk("redir_re", 32'(mem_re), 32'd1);
      chk("redir_addr", 32'(memaddr), 32'h7FFF);
      chk("redir_valid", 32'(inst_valid), 32'd0);
      wait_valid(n);
      check_inst(15'h7FFF, 4, n);
      chk_reads("wrap_reads", '{15'h7FFF, 15'h0000});
      accept(1'b0, 1'b0, '0);
      chk("wrap_next", 32'(memaddr), 32'h0001);

      exp_pc = 15'h0001;
      lat = 2 * int'(ref_at(exp_pc).len);
      for (int it = 0; it < 80; it++) begin
         wait_valid(n);
         check_inst(exp_pc, lat, n);
         r = ref_at(exp_pc);
         nxt = 15'(exp_pc + 15'(r.len));
         k = int'($urandom_range(0, 3));
         for (int j = 0; j < k; j++) begin
            step();
            chk("rnd_hold", {15'd0, inst_valid, inst_word}, {15'd0, 1'b1, r.word});
         end
         s   = ($urandom_range(0, 2) == 0);
         rd  = ($urandom_range(0, 4) == 0);
         tgt = 15'($urandom);
         accept(s, rd, tgt);
         if (rd) begin
            exp_pc = tgt;
            lat = 2 * int'(ref_at(exp_pc).len);
         end else if (s) begin
            rs = ref_at(nxt);
            exp_pc = 15'(nxt + 15'(rs.len));
            lat = 2 * int'(rs.len) + 2 * int'(ref_at(exp_pc).len);
         end else begin
            exp_pc = nxt;
            lat = 2 * int'(ref_at(exp_pc).len);
         end
         if (!rd && $urandom_range(0, 5) == 0) begin
            k = int'($urandom_range(0, 1));
            for (int j = 0; j < k; j++) step();
            tgt = 15'($urandom);
            redirect = 1'b1; redirect_pc = tgt;
            step();
            redirect = 1'b0;
            exp_pc = tgt;
            lat = 2 * int'(ref_at(exp_pc).len);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcpu_ifetch.md
Name: dcpu_ifetch

Overview:
Parametrised instruction-fetch front end for the DCPU-16 core. Replaces the fixed two-state FETCH/DECODE loop. Assembles complete variable-length instructions (opcode word plus 0–2 next-word operands) from synchronous memory and hands them to decode over a valid/ready handshake. Also executes branch redirects and IF*-style skips.

Parameters:
AWIDTH, 16, byte-address width; word address is AWIDTH-1 bits
DWIDTH, 16, memory/instruction word width
RESET_PC, 0, word address of the first fetch after reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_re  out  1  memory read strobe
memaddr  out  AWIDTH-1  word address, valid while mem_re=1
rmemdata  in  DWIDTH  read data, valid the cycle after mem_re
inst_valid  out  1  assembled instruction available
inst_ready  in  1  decode accepts the instruction
inst_word  out  DWIDTH  opcode word
inst_ext_a  out  DWIDTH  next word for operand a (0 if unused)
inst_ext_b  out  DWIDTH  next word for operand b (0 if unused)
inst_len  out  2  instruction length in words, 1..3
inst_pc  out  AWIDTH-1  address of the opcode word
skip  in  1  discard the next instruction; sampled only on accept
redirect  in  1  abort and refetch at redirect_pc, any cycle
redirect_pc  in  AWIDTH-1  redirect target

Behaviour:
- Reset: state=RST, pc=RESET_PC, skip_pending=0. Every output is 0: mem_re, inst_valid, inst_word, inst_ext_a, inst_ext_b, inst_len, inst_pc. memaddr=0.
- The first cycle after rst falls goes RST->REQ_OP.
- Reset during any state takes effect on the next edge and discards all in-flight state.
- Word format: op=ir[3:0], a=ir[9:4], b=ir[15:10].
- A field needs a next word when its code is 0x10–0x17, 0x1e or 0x1f.
- Basic instruction (op≠0): both a and b are checked. The a word is fetched first.
- Non-basic instruction (op=0): ir[9:4] is the sub-opcode and only ir[15:10] is checked. Its word goes to inst_ext_a.
- States: RST, REQ_OP, CAP_OP, REQ_A, CAP_A, REQ_B, CAP_B, OUT.
- REQ_*: mem_re=1, memaddr=fetch pointer. The fetch pointer advances by 1, modulo 2^(AWIDTH-1); 0x7FFF wraps to 0x0000.
- CAP_*: latch rmemdata into the matching field, then:
  - CAP_OP: go to REQ_A if any next word is needed. A basic instruction needing only b still uses the REQ_A/CAP_A slot order, with the data routed to inst_ext_b.
  - CAP_A: go to REQ_B if a second word is needed.
  - Otherwise the instruction is complete.
- On completion:
  - skip_pending=0: go to OUT.
  - skip_pending=1: clear skip_pending and go to REQ_OP. No inst_valid is raised.
- OUT: inst_valid=1. All inst_* outputs are held stable while inst_ready=0, and mem_re=0.
- Accept (inst_valid & inst_ready): go to REQ_OP at the next edge. skip_pending <= skip.
- Latency from entering REQ_OP to inst_valid: 2/4/6 cycles for lengths 1/2/3. One instruction is in flight at a time; there is no prefetch.
- Redirect:
  - redirect=1 in any non-RST state: next state REQ_OP, fetch pointer=redirect_pc, skip_pending=0, inst_valid=0 next cycle.
  - Partially fetched words are dropped.
  - Redirect coincident with accept: the accept completes, and the redirect wins for the pointer and for skip (skip is ignored).
  - Redirect during RST is ignored.
- mem_re is never asserted in CAP_*, OUT or RST.
- inst_len is 1 + the number of next words fetched.
- inst_pc + inst_len, modulo 2^(AWIDTH-1), equals the next opcode address absent a redirect.

Decomposition:
- dcpu_pkg holds:
  - the state encoding
  - the operand-code constants (NEXTWORD_IND_LO=0x10, NEXTWORD_IND_HI=0x17, NEXTWORD_ADDR=0x1e, NEXTWORD_LIT=0x1f)
  - the field bit positions
- One combinational sub-module, dcpu_oplen: opcode word in; need_a, need_b, len out. Decode reuses it for operand sequencing.

Test Plan:
- Reset with RESET_PC=0x0100; memory[0x100]=0x0402 (ADD A,B) -> mem_re @0x0100 in the first REQ_OP; inst_valid 2 cycles later; inst_word=0x0402, inst_len=1, inst_pc=0x0100, ext_a=ext_b=0; next fetch at 0x0101.
- memory[p]=0x7C01, [p+1]=0x0030 (SET A,0x30) -> inst_len=2, inst_ext_b=0x0030, inst_ext_a=0. Non-basic 0x7C10 followed by 0x1234 -> inst_len=2, inst_ext_a=0x1234.
- 0x79E1, 0x1000, 0x2000 at p -> reads at p,p+1,p+2; inst_valid 6 cycles after REQ_OP; ext_a=0x1000, ext_b=0x2000, len=3.
- Hold inst_ready=0 for 5 cycles in OUT -> outputs unchanged, mem_re=0 throughout; accept on cycle 6 -> REQ_OP at pc+len.
- Accept with skip=1, next instruction 0x79E1 at q -> reads at q..q+2 with no inst_valid; next inst_valid carries inst_pc=q+3.
- redirect=1 with redirect_pc=0x7FFF during CAP_A -> next cycle mem_re @0x7FFF; aborted instruction never valid. Len-2 instruction at 0x7FFF reads its next word at 0x0000.
